// File: rtl/sqrt_arbiter_if.sv
// rtl/sqrt_arbiter_if.sv - requester, Sqrt core and result signals of the two-port sqrt arbiter
interface sqrt_arbiter_if #(
    parameter int IN_W  = 31,
    parameter int OUT_W = 17
);
    logic             en;
    logic             req0;
    logic [IN_W-1:0]  din0;
    logic             gnt0;
    logic             req1;
    logic [IN_W-1:0]  din1;
    logic             gnt1;
    logic [IN_W-1:0]  sqrt_in;
    logic [OUT_W-1:0] sqrt_out;
    logic             res0_valid;
    logic [OUT_W-1:0] res0_data;
    logic             res1_valid;
    logic [OUT_W-1:0] res1_data;
    logic             busy;

    // requesters plus the Sqrt core, seen from outside the arbiter
    modport master (
        output en, req0, din0, req1, din1, sqrt_out,
        input  gnt0, gnt1, sqrt_in, res0_valid, res0_data, res1_valid, res1_data, busy
    );

    // the arbiter itself
    modport slave (
        input  en, req0, din0, req1, din1, sqrt_out,
        output gnt0, gnt1, sqrt_in, res0_valid, res0_data, res1_valid, res1_data, busy
    );
endinterface

// File: rtl/sqrt_arbiter.sv
// rtl/sqrt_arbiter.sv - round-robin sharing of one pipelined Sqrt core between two requesters
module sqrt_arbiter #(
    parameter int IN_W     = 31,
    parameter int OUT_W    = 17,
    parameter int SQRT_LAT = 2
) (
    input  logic          clk,
    input  logic          rst,
    sqrt_arbiter_if.slave bus
);
    localparam int NSTG  = SQRT_LAT + 1;
    localparam int CNT_W = $clog2(SQRT_LAT + 2);

    logic              r_ptr;
    logic [IN_W-1:0]   r_sqrt_in;
    logic [NSTG-1:0]   r_tag_vld;
    logic [NSTG-1:0]   r_tag_id;
    logic              r_res0_valid;
    logic              r_res1_valid;
    logic [OUT_W-1:0]  r_res0_data;
    logic [OUT_W-1:0]  r_res1_data;
    logic [CNT_W-1:0]  r_cnt;

    logic              w_gnt0;
    logic              w_gnt1;
    logic              w_acc;
    logic              w_ret;
    logic              w_ret_id;

    // r_ptr=0 favours requester 0 on contention; rst gating keeps grants low during reset
    assign w_gnt0   = rst & bus.en & bus.req0 & (~bus.req1 | ~r_ptr);
    assign w_gnt1   = rst & bus.en & bus.req1 & (~bus.req0 |  r_ptr);
    assign w_acc    = w_gnt0 | w_gnt1;
    // last tag stage lines up with the sqrt_out of the operand it describes
    assign w_ret    = r_tag_vld[NSTG-1];
    assign w_ret_id = r_tag_id[NSTG-1];

    // priority pointer moves to the loser after each grant, holds otherwise
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ptr <= 1'b0;
        end else if (w_acc) begin
            r_ptr <= w_gnt0;
        end
    end

    // operand register feeding the core; zero on idle cycles
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sqrt_in <= '0;
        end else if (w_gnt1) begin
            r_sqrt_in <= bus.din1;
        end else if (w_gnt0) begin
            r_sqrt_in <= bus.din0;
        end else begin
            r_sqrt_in <= '0;
        end
    end

    // {valid, id} tags travel alongside the operand through the core latency
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tag_vld <= '0;
            r_tag_id  <= '0;
        end else begin
            r_tag_vld <= {r_tag_vld[NSTG-2:0], w_acc};
            r_tag_id  <= {r_tag_id[NSTG-2:0], w_gnt1};
        end
    end

    // route the returning core result to its owner; data holds between strobes
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_res0_valid <= 1'b0;
            r_res1_valid <= 1'b0;
            r_res0_data  <= '0;
            r_res1_data  <= '0;
        end else begin
            r_res0_valid <= w_ret & ~w_ret_id;
            r_res1_valid <= w_ret &  w_ret_id;
            if (w_ret && !w_ret_id) begin
                r_res0_data <= bus.sqrt_out;
            end
            if (w_ret && w_ret_id) begin
                r_res1_data <= bus.sqrt_out;
            end
        end
    end

    // in-flight count: up on acceptance, down as a result is registered out
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else begin
            case ({w_acc, w_ret})
                2'b10:   r_cnt <= r_cnt + CNT_W'(1);
                2'b01:   r_cnt <= r_cnt - CNT_W'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    assign bus.gnt0       = w_gnt0;
    assign bus.gnt1       = w_gnt1;
    assign bus.sqrt_in    = r_sqrt_in;
    assign bus.res0_valid = r_res0_valid;
    assign bus.res0_data  = r_res0_data;
    assign bus.res1_valid = r_res1_valid;
    assign bus.res1_data  = r_res1_data;
    assign bus.busy       = (r_cnt != '0);
endmodule
